// File: rtl/tx_trn_arbiter_if.sv
// TX TRN arbitration bundle: client request/drive handshake, packed client
// buses and the muxed bus toward the core.
interface tx_trn_arbiter_if;
  logic [2:0]   req;
  logic [2:0]   drv;
  logic [2:0]   my_turn;
  logic [191:0] c_td;
  logic [23:0]  c_trem_n;
  logic [2:0]   c_tsof_n;
  logic [2:0]   c_teof_n;
  logic [2:0]   c_tsrc_rdy_n;
  logic [63:0]  trn_td;
  logic [7:0]   trn_trem_n;
  logic         trn_tsof_n;
  logic         trn_teof_n;
  logic         trn_tsrc_rdy_n;

  modport master (
    input  req, drv, c_td, c_trem_n, c_tsof_n, c_teof_n, c_tsrc_rdy_n,
    output my_turn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
  );

  modport slave (
    output req, drv, c_td, c_trem_n, c_tsof_n, c_teof_n, c_tsrc_rdy_n,
    input  my_turn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
  );
endinterface

// File: rtl/tx_trn_arbiter.sv
// Round-robin arbiter for three TX TRN clients sharing one core TX port,
// with grant timeout, one-cycle release gap and sticky collision detection.
module tx_trn_arbiter #(
  parameter int unsigned GRANT_WAIT = 16
) (
  input  logic                   trn_clk,
  input  logic                   reset_n,
  tx_trn_arbiter_if.master       bus,
  output logic [1:0]             owner,
  output logic                   busy,
  output logic                   grant_timeout,
  output logic                   collision_err
);

  localparam logic [3:0] IDLE    = 4'b0001;
  localparam logic [3:0] GRANT   = 4'b0010;
  localparam logic [3:0] BUSY    = 4'b0100;
  localparam logic [3:0] RELEASE = 4'b1000;

  logic [3:0] state_q, state_d;
  logic [2:0] my_turn_q, my_turn_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_owner_q, last_owner_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       grant_timeout_q, grant_timeout_d;
  logic       collision_q, collision_d;

  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic [2:0] owner_oh;
  logic       drv_own;
  logic       coll_now;

  assign owner_oh = 3'b001 << owner_q;
  assign drv_own  = |(bus.drv & owner_oh);
  assign coll_now = (|(bus.drv & ~owner_oh)) || ((state_q == IDLE) && (|bus.drv));

  // Search starts one past the last owner so every client gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = 2'((32'(last_owner_q) + k + 32'd1) % 32'd3);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    my_turn_d       = my_turn_q;
    owner_d         = owner_q;
    last_owner_d    = last_owner_q;
    wait_cnt_d      = wait_cnt_q;
    grant_timeout_d = 1'b0;
    collision_d     = collision_q | coll_now;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (|bus.req) begin
          state_d   = GRANT;
          owner_d   = winner;
          my_turn_d = 3'b001 << winner;
        end
      end
      GRANT: begin
        // drv wins over a timeout expiring on the same edge
        if (drv_own) begin
          state_d    = BUSY;
          my_turn_d  = '0;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == 8'(GRANT_WAIT - 1)) begin
          state_d         = IDLE;
          my_turn_d       = '0;
          wait_cnt_d      = '0;
          grant_timeout_d = 1'b1;
          last_owner_d    = owner_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      BUSY: begin
        if (!drv_own) begin
          state_d      = RELEASE;
          last_owner_d = owner_q;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d    = IDLE;
        my_turn_d  = '0;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      my_turn_q       <= '0;
      owner_q         <= 2'd0;
      last_owner_q    <= 2'd2;
      wait_cnt_q      <= '0;
      grant_timeout_q <= 1'b0;
      collision_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      my_turn_q       <= my_turn_d;
      owner_q         <= owner_d;
      last_owner_q    <= last_owner_d;
      wait_cnt_q      <= wait_cnt_d;
      grant_timeout_q <= grant_timeout_d;
      collision_q     <= collision_d;
    end
  end

  // Bus mux follows the owner in every non-IDLE state, so reset drops it at once.
  always_comb begin
    bus.trn_td         = '0;
    bus.trn_trem_n     = '1;
    bus.trn_tsof_n     = 1'b1;
    bus.trn_teof_n     = 1'b1;
    bus.trn_tsrc_rdy_n = 1'b1;
    if (state_q != IDLE) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (owner_q == 2'(i)) begin
          bus.trn_td         = bus.c_td[64*i +: 64];
          bus.trn_trem_n     = bus.c_trem_n[8*i +: 8];
          bus.trn_tsof_n     = bus.c_tsof_n[i];
          bus.trn_teof_n     = bus.c_teof_n[i];
          bus.trn_tsrc_rdy_n = bus.c_tsrc_rdy_n[i];
        end
      end
    end
  end

  assign bus.my_turn    = my_turn_q;
  assign owner          = owner_q;
  assign busy           = (state_q == GRANT) || (state_q == BUSY);
  assign grant_timeout  = grant_timeout_q;
  assign collision_err  = collision_q;

endmodule

// File: tb/tb_tx_trn_arbiter.sv
// Self-checking bench for tx_trn_arbiter: grant scoreboard plus directed
// checks of mux, timeout, race, collision and reset behaviour.
module tb_tx_trn_arbiter;
  logic       trn_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] owner;
  logic       busy;
  logic       grant_timeout;
  logic       collision_err;

  tx_trn_arbiter_if bus();

  tx_trn_arbiter #(.GRANT_WAIT(16)) dut (
    .trn_clk       (trn_clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .owner         (owner),
    .busy          (busy),
    .grant_timeout (grant_timeout),
    .collision_err (collision_err)
  );

  always #5 trn_clk = ~trn_clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [2:0] grant_q[$];
  logic [2:0] prev_turn = '0;
  logic [2:0] exp_g;
  logic [63:0] cd [3];
  logic [1:0] rr_exp [4];
  int         cyc;
  int         hi;
  int         tp;
  logic [2:0] cur;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic load_data();
    bus.c_td = {cd[2], cd[1], cd[0]};
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.drv = '0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_turn(output int c);
    c = 0;
    while (bus.my_turn == 3'b000 && c < 40) begin
      step();
      c++;
    end
    chk("turn_seen", 64'(bus.my_turn != 3'b000), 64'd1);
  endtask

  // Every new grant is matched against the order queued with the stimulus.
  always @(negedge trn_clk) begin
    if (reset_n && bus.my_turn != 3'b000 && prev_turn == 3'b000) begin
      if (grant_q.size() == 0) begin
        chk("grant_unexpected", 64'(bus.my_turn), 64'd0);
      end else begin
        exp_g = grant_q.pop_front();
        chk("grant_order", 64'(bus.my_turn), 64'(exp_g));
      end
    end
    prev_turn = bus.my_turn;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cd[0] = 64'hA0A0_0000_1111_2222;
    cd[1] = 64'hB1B1_3333_4444_5555;
    cd[2] = 64'hC2C2_6666_7777_8888;
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd0;
    load_data();
    bus.c_trem_n     = {8'h3C, 8'h2B, 8'h1A};
    bus.c_tsof_n     = 3'b000;
    bus.c_teof_n     = 3'b000;
    bus.c_tsrc_rdy_n = 3'b000;
    bus.req = '0;
    bus.drv = '0;

    // reset values
    step();
    step();
    chk("rst_my_turn", 64'(bus.my_turn), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout", 64'(grant_timeout), 64'd0);
    chk("rst_coll", 64'(collision_err), 64'd0);
    chk("rst_td", bus.trn_td, 64'd0);
    chk("rst_trem", 64'(bus.trn_trem_n), 64'hFF);
    chk("rst_rdy", 64'({bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n}), 64'h7);
    reset_n = 1'b1;
    step();

    // single client 1
    grant_q.push_back(3'b010);
    bus.req = 3'b010;
    step();
    chk("t1_turn", 64'(bus.my_turn), 64'h2);
    chk("t1_owner", 64'(owner), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    step();
    bus.drv = 3'b010;
    bus.req = 3'b000;
    step();
    chk("t1_busy_turn", 64'(bus.my_turn), 64'd0);
    chk("t1_td", bus.trn_td, cd[1]);
    chk("t1_trem", 64'(bus.trn_trem_n), 64'h2B);
    cd[1] = 64'hB1B1_DEAD_BEEF_0001;
    load_data();
    #1;
    chk("t1_td_track", bus.trn_td, 64'hB1B1_DEAD_BEEF_0001);
    step();
    bus.drv = 3'b000;
    step();
    chk("t1_release_busy", 64'(busy), 64'd0);
    chk("t1_release_td", bus.trn_td, cd[1]);
    step();
    chk("t1_idle_td", bus.trn_td, 64'd0);
    chk("t1_idle_rdy", 64'(bus.trn_tsrc_rdy_n), 64'd1);
    chk("t1_idle_owner", 64'(owner), 64'd1);
    chk("t1_coll", 64'(collision_err), 64'd0);

    // fairness with all clients requesting
    do_reset();
    for (int g = 0; g < 4; g++) grant_q.push_back(3'b001 << rr_exp[g]);
    bus.req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_turn(cyc);
      if (g > 0) chk("rr_gap", 64'(cyc), 64'd3);
      chk("rr_owner", 64'(owner), 64'(rr_exp[g]));
      if (g == 3) bus.req = 3'b000;
      cur = bus.my_turn;
      bus.drv = cur;
      step();
      chk("rr_busy_turn", 64'(bus.my_turn), 64'd0);
      step();
      step();
      bus.drv = 3'b000;
    end
    repeat (3) step();

    // grant timeout on client 0, then client 1
    do_reset();
    grant_q.push_back(3'b001);
    grant_q.push_back(3'b010);
    bus.req = 3'b011;
    step();
    hi = 0;
    tp = 0;
    while (bus.my_turn[0] && hi < 40) begin
      hi++;
      step();
      if (grant_timeout) tp++;
    end
    chk("to_cycles", 64'(hi), 64'd16);
    chk("to_pulses", 64'(tp), 64'd1);
    step();
    chk("to_next_turn", 64'(bus.my_turn), 64'h2);
    chk("to_pulse_end", 64'(grant_timeout), 64'd0);
    chk("to_next_owner", 64'(owner), 64'd1);
    bus.req = 3'b000;
    bus.drv = 3'b010;
    step();
    bus.drv = 3'b000;
    repeat (3) step();

    // drv rises on the expiry edge
    do_reset();
    grant_q.push_back(3'b001);
    bus.req = 3'b001;
    step();
    repeat (15) step();
    chk("race_pre_turn", 64'(bus.my_turn), 64'h1);
    bus.drv = 3'b001;
    bus.req = 3'b000;
    step();
    chk("race_turn", 64'(bus.my_turn), 64'd0);
    chk("race_no_pulse", 64'(grant_timeout), 64'd0);
    chk("race_busy", 64'(busy), 64'd1);
    bus.drv = 3'b000;
    repeat (3) step();

    // collision while client 0 owns the bus
    do_reset();
    grant_q.push_back(3'b001);
    bus.req = 3'b001;
    step();
    bus.req = 3'b000;
    bus.drv = 3'b001;
    step();
    chk("coll_before", 64'(collision_err), 64'd0);
    bus.drv = 3'b101;
    step();
    bus.drv = 3'b001;
    chk("coll_set", 64'(collision_err), 64'd1);
    chk("coll_td", bus.trn_td, cd[0]);
    chk("coll_owner", 64'(owner), 64'd0);
    step();
    chk("coll_held", 64'(collision_err), 64'd1);
    chk("coll_busy", 64'(busy), 64'd1);
    bus.drv = 3'b000;
    step();
    step();
    chk("coll_sticky_idle", 64'(collision_err), 64'd1);

    // asynchronous reset in the middle of BUSY
    grant_q.push_back(3'b010);
    bus.req = 3'b010;
    step();
    bus.req = 3'b000;
    bus.drv = 3'b010;
    step();
    chk("rb_busy", 64'(busy), 64'd1);
    chk("rb_rdy_owned", 64'(bus.trn_tsrc_rdy_n), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("rb_rdy", 64'(bus.trn_tsrc_rdy_n), 64'd1);
    chk("rb_turn", 64'(bus.my_turn), 64'd0);
    chk("rb_coll", 64'(collision_err), 64'd0);
    chk("rb_busy_off", 64'(busy), 64'd0);
    bus.drv = 3'b000;
    step();
    reset_n = 1'b1;
    grant_q.push_back(3'b001);
    bus.req = 3'b011;
    step();
    chk("rb_first", 64'(bus.my_turn), 64'h1);
    chk("rb_owner", 64'(owner), 64'd0);
    bus.req = 3'b000;
    bus.drv = 3'b001;
    step();
    bus.drv = 3'b000;
    repeat (3) step();

    chk("sb_empty", 64'(grant_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
